mul_res_stage: RTL



---
 rtl/mul_res_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/mul_res_stage.sv
// Registered result stage behind the fp32 multiplier: 2-entry skid FIFO with IEEE class tags,
// sticky class flags and a saturating delivered-result counter.
module mul_res_stage #(
   parameter int unsigned SIGN_W = 1,
   parameter int unsigned EXPO_W = 8,
   parameter int unsigned MANT_W = 23,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_vld,
   output logic                              in_rdy,
   input  logic [SIGN_W+EXPO_W+MANT_W-1:0]   in_res,
   output logic                              out_vld,
   input  logic                              out_rdy,
   output logic [SIGN_W+EXPO_W+MANT_W-1:0]   out_res,
   output logic [2:0]                        out_cls,
   input  logic                              flag_clr,
   output logic                              flg_nan,
   output logic                              flg_inf,
   output logic                              flg_sub,
   output logic                              flg_zero,
   output logic [CNT_W-1:0]                  res_cnt
);

   localparam int unsigned W = SIGN_W + EXPO_W + MANT_W;
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [EXPO_W-1:0] expo;
   logic [MANT_W-1:0] mant;
   logic [2:0]        in_cls;

   logic [W-1:0] dat_q [2];
   logic [2:0]   cls_q [2];
   logic         rd_ptr_q, wr_ptr_q;
   logic [1:0]   occ_q, occ_d;
   logic         in_rdy_q;
   logic [3:0]   flg_q, flg_d, flg_set;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic         push, pop;

   assign expo = in_res[MANT_W +: EXPO_W];
   assign mant = in_res[MANT_W-1:0];

   always_comb begin
      in_cls = 3'b000;
      if (&expo) begin
         if (mant == '0)           in_cls = 3'b011;
         else if (mant[MANT_W-1])  in_cls = 3'b100;
         else                      in_cls = 3'b101;
      end else if (expo == '0) begin
         in_cls = (mant == '0) ? 3'b001 : 3'b010;
      end
   end

   assign push = in_vld & in_rdy_q;
   assign pop  = out_vld & out_rdy;

   // in_rdy is registered from next occupancy so out_rdy never reaches the multiplier path.
   assign occ_d = occ_q + 2'(push) - 2'(pop);

   always_comb begin
      flg_set = 4'b0000;
      if (push) begin
         flg_set[3] = (in_cls == 3'b100) | (in_cls == 3'b101);
         flg_set[2] = (in_cls == 3'b011);
         flg_set[1] = (in_cls == 3'b010);
         flg_set[0] = (in_cls == 3'b001);
      end
      // Clear takes effect before a same-cycle set.
      flg_d = (flag_clr ? 4'b0000 : flg_q) | flg_set;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (flag_clr)                   cnt_d = CNT_W'(pop);
      else if (pop && cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            dat_q[i] <= '0;
            cls_q[i] <= 3'b000;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         in_rdy_q <= 1'b1;
         flg_q    <= 4'b0000;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            dat_q[wr_ptr_q] <= in_res;
            cls_q[wr_ptr_q] <= in_cls;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         occ_q    <= occ_d;
         in_rdy_q <= (occ_d != 2'd2);
         flg_q    <= flg_d;
         cnt_q    <= cnt_d;
      end
   end

   assign in_rdy   = in_rdy_q;
   assign out_vld  = (occ_q != 2'd0);
   assign out_res  = dat_q[rd_ptr_q];
   assign out_cls  = cls_q[rd_ptr_q];
   assign flg_nan  = flg_q[3];
   assign flg_inf  = flg_q[2];
   assign flg_sub  = flg_q[1];
   assign flg_zero = flg_q[0];
   assign res_cnt  = cnt_q;

endmodule
